// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-side memory bridge.
// Translation constants are used when CPU_MEM_BRIDGE_KSEG_XLATE_EN is defined.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } bridgeState_e;

  localparam logic [2:0] KSEG0_TAG = 3'b100;
  localparam logic [2:0] KSEG1_TAG = 3'b101;
  localparam int PHYS_MASK_BITS = 29;

  function automatic logic isKseg(
    input logic [2:0] tag
  );
    return (tag == KSEG0_TAG) ||
           (tag == KSEG1_TAG);
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_rr_arbiter.sv
// Round-robin arbiter: ptr is the index holding
// highest priority this cycle; returns one-hot grant and index.
module rr_arbiter #(
  parameter int NCH = 2,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           valid
);
  import cpu_mem_pkg::*;

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(ptr) + i;
      if (j >= NCH) j = j - NCH;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Arbitrates CPU request channels onto one split-transaction SRAM-like bus.
// Define CPU_MEM_BRIDGE_KSEG_XLATE_EN to map kseg0/kseg1 to physical.
module cpu_mem_bridge
  import cpu_mem_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  localparam int SW = DW / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*SW-1:0] ch_wen,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH*DW-1:0] ch_rdata,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_busy,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [SW-1:0]     bus_wstrb,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DW-1:0]     bus_rdata
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  bridgeState_e state, stateNext;

  logic [IW-1:0]     grantIdx;
  logic [NCH-1:0]    grantOh;
  logic [IW-1:0]     rrPtr;
  logic              ptrValid;
  logic [AW-1:0]     addrReg;
  logic [SW-1:0]     wenReg;
  logic [DW-1:0]     wdataReg;
  logic [NCH-1:0]    doneReg;
  logic [NCH*DW-1:0] rdataReg;

  logic [NCH-1:0] reqEff;
  logic [NCH-1:0] arbGnt;
  logic [IW-1:0]  arbIdx;
  logic [IW-1:0]  arbPtr;
  logic           arbValid;
  logic [AW-1:0]  selAddr;
  logic [AW-1:0]  physAddr;

  // A channel in its done cycle still shows req; keep it from re-winning.
  assign reqEff = ch_req & ~doneReg;

  assign arbPtr = !ptrValid ? '0 :
                  (rrPtr == IW'(NCH - 1)) ? '0 :
                  rrPtr + 1'b1;

  rr_arbiter #(
    .NCH(NCH)
  ) uArb (
    .req  (reqEff),
    .ptr  (arbPtr),
    .gnt  (arbGnt),
    .idx  (arbIdx),
    .valid(arbValid)
  );

  assign selAddr = ch_addr[int'(arbIdx)*AW +: AW];

`ifdef CPU_MEM_BRIDGE_KSEG_XLATE_EN
  localparam logic [AW-1:0] PHYS_MASK =
    AW'({PHYS_MASK_BITS{1'b1}});

  always_comb begin
    physAddr = selAddr;
    if (isKseg(selAddr[AW-1 -: 3]))
      physAddr = selAddr & PHYS_MASK;
  end
`else
  assign physAddr = selAddr;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (arbValid)    stateNext = ADDR;
      ADDR: if (bus_addr_ok) stateNext = DATA;
      DATA: if (bus_data_ok) stateNext = IDLE;
      default:               stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grantIdx <= '0;
      grantOh  <= '0;
      rrPtr    <= '0;
      ptrValid <= 1'b0;
      addrReg  <= '0;
      wenReg   <= '0;
      wdataReg <= '0;
      doneReg  <= '0;
      rdataReg <= '0;
    end else begin
      doneReg <= '0;
      if (state == IDLE && arbValid) begin
        grantIdx <= arbIdx;
        grantOh  <= arbGnt;
        rrPtr    <= arbIdx;
        ptrValid <= 1'b1;
        addrReg  <= physAddr;
        wenReg   <= ch_wen[int'(arbIdx)*SW +: SW];
        wdataReg <= ch_wdata[int'(arbIdx)*DW +: DW];
      end
      // A flushed channel still lets the bus finish, silently.
      if (state == DATA && bus_data_ok &&
          ch_req[grantIdx]) begin
        doneReg <= grantOh;
        if (wenReg == '0)
          rdataReg[int'(grantIdx)*DW +: DW] <= bus_rdata;
      end
    end
  end

  assign bus_req   = (state == ADDR);
  assign bus_wr    = |wenReg;
  assign bus_wstrb = wenReg;
  assign bus_addr  = addrReg;
  assign bus_wdata = wdataReg;
  assign ch_done   = doneReg;
  assign ch_rdata  = rdataReg;
  assign ch_busy   = (state != IDLE) ? grantOh : '0;

endmodule
